// File: rtl/naive_bus_rr_arbiter.sv
// Round-robin naive_bus arbiter with grant quantum and registered read return.
// Optional starvation monitor built when NB_ARB_STARVE_MON_EN is defined.
module naive_bus_rr_arbiter #(
    parameter int N_MASTER     = 3,
    parameter int QUANTUM      = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_MASTER-1:0]    m_rd_req,
    input  logic [N_MASTER*32-1:0] m_rd_addr,
    output logic [N_MASTER-1:0]    m_rd_gnt,
    output logic [N_MASTER*32-1:0] m_rd_data,
    input  logic [N_MASTER-1:0]    m_wr_req,
    input  logic [N_MASTER*32-1:0] m_wr_addr,
    input  logic [N_MASTER*4-1:0]  m_wr_be,
    input  logic [N_MASTER*32-1:0] m_wr_data,
    output logic [N_MASTER-1:0]    m_wr_gnt,
    output logic                   s_rd_req,
    output logic                   s_wr_req,
    output logic [31:0]            s_rd_addr,
    output logic [31:0]            s_wr_addr,
    output logic [3:0]             s_wr_be,
    output logic [31:0]            s_wr_data,
    input  logic                   s_rd_gnt,
    input  logic                   s_wr_gnt,
    input  logic [31:0]            s_rd_data,
    output logic [N_MASTER-1:0]    o_starve
);

    localparam int OW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam logic [7:0] QMAX = 8'(QUANTUM);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       w_owner_nx;
    logic [7:0]          r_qcnt;
    logic [7:0]          w_qcnt_nx;
    logic                r_rd_pend;
    logic [OW-1:0]       r_rd_id;

    logic [N_MASTER-1:0] w_req;
    logic [N_MASTER-1:0] w_own_oh;
    logic                w_others;
    logic                w_keep;
    logic [OW-1:0]       w_start;
    logic [OW-1:0]       w_idx;
    logic [OW-1:0]       w_sel;
    logic                w_sel_vld;
    logic [OW+4:0]       w_base;
    logic [OW+4:0]       w_rbase;
    logic                w_rd_hs;
    logic                w_wr_hs;

    assign w_req    = m_rd_req | m_wr_req;
    assign w_own_oh = {{(N_MASTER-1){1'b0}}, 1'b1} << r_owner;
    assign w_others = |(w_req & ~w_own_oh);

    always_comb begin
        int j;
        j      = 0;
        w_idx  = '0;
        w_keep = (r_state == OWNED) && w_req[r_owner]
                 && ((r_qcnt < QMAX) || !w_others);
        if (r_state == IDLE || int'(r_owner) == N_MASTER - 1) begin
            w_start = '0;
        end else begin
            w_start = r_owner + 1'b1;
        end
        w_sel     = r_owner;
        w_sel_vld = w_keep;
        // Rotating scan visits the owner last, so it wins only if alone.
        if (!w_keep) begin
            for (int k = 0; k < N_MASTER; k++) begin
                j = int'(w_start) + k;
                if (j >= N_MASTER) j = j - N_MASTER;
                w_idx = OW'(j);
                if (!w_sel_vld && w_req[w_idx]) begin
                    w_sel_vld = 1'b1;
                    w_sel     = w_idx;
                end
            end
        end
        if (rst) w_sel_vld = 1'b0;
    end

    assign w_base  = {w_sel, 5'd0};
    assign w_rbase = {r_rd_id, 5'd0};

    always_comb begin
        s_rd_req  = w_sel_vld & m_rd_req[w_sel];
        s_wr_req  = w_sel_vld & m_wr_req[w_sel] & ~m_rd_req[w_sel];
        s_rd_addr = '0;
        s_wr_addr = '0;
        s_wr_be   = '0;
        s_wr_data = '0;
        if (w_sel_vld) begin
            s_rd_addr = m_rd_addr[w_base +: 32];
            s_wr_addr = m_wr_addr[w_base +: 32];
            s_wr_be   = m_wr_be[{w_sel, 2'd0} +: 4];
            s_wr_data = m_wr_data[w_base +: 32];
        end
        w_rd_hs  = s_rd_req & s_rd_gnt;
        w_wr_hs  = s_wr_req & s_wr_gnt;
        m_rd_gnt = '0;
        m_wr_gnt = '0;
        m_rd_gnt[w_sel] = w_rd_hs;
        m_wr_gnt[w_sel] = w_wr_hs;
        m_rd_data = '0;
        if (r_rd_pend && !rst) m_rd_data[w_rbase +: 32] = s_rd_data;
    end

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_qcnt_nx  = r_qcnt;
        if (w_rd_hs || w_wr_hs) begin
            w_state_nx = OWNED;
            if (w_sel == r_owner) begin
                w_qcnt_nx = (r_qcnt >= QMAX) ? QMAX : r_qcnt + 8'd1;
            end else begin
                w_owner_nx = w_sel;
                w_qcnt_nx  = 8'd1;
            end
        end else if (r_state == OWNED && !(|w_req)) begin
            w_state_nx = IDLE;
            w_qcnt_nx  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_qcnt    <= '0;
            r_rd_pend <= 1'b0;
            r_rd_id   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_owner   <= w_owner_nx;
            r_qcnt    <= w_qcnt_nx;
            r_rd_pend <= w_rd_hs;
            r_rd_id   <= w_sel;
        end
    end

`ifdef NB_ARB_STARVE_MON_EN
    localparam logic [15:0] SLIM = 16'(STARVE_LIMIT);

    logic [15:0]         r_wait [N_MASTER];
    logic [N_MASTER-1:0] r_starve;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_MASTER; i++) r_wait[i] <= '0;
            r_starve <= '0;
        end else begin
            for (int i = 0; i < N_MASTER; i++) begin
                if (!w_req[i] || m_rd_gnt[i] || m_wr_gnt[i]) begin
                    r_wait[i] <= '0;
                end else begin
                    if (r_wait[i] != 16'hFFFF) r_wait[i] <= r_wait[i] + 16'd1;
                    if (r_wait[i] + 16'd1 >= SLIM) r_starve[i] <= 1'b1;
                end
            end
        end
    end

    assign o_starve = rst ? '0 : r_starve;
`else
    logic w_unused_slim;
    assign w_unused_slim = ^(16'(STARVE_LIMIT));
    assign o_starve      = '0;
`endif

endmodule

// File: tb/tb_naive_bus_rr_arbiter.sv
// Self-checking bench for naive_bus_rr_arbiter: vector table, corner
// sequences and a randomized run against a rule-level reference model.
module tb_naive_bus_rr_arbiter;

    localparam int N  = 3;
    localparam int Q  = 4;
    localparam int SL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]    m_rd_req, m_wr_req, m_rd_gnt, m_wr_gnt, o_starve;
    logic [N*32-1:0] m_rd_addr, m_rd_data, m_wr_addr, m_wr_data;
    logic [N*4-1:0]  m_wr_be;
    logic          s_rd_req, s_wr_req, s_rd_gnt, s_wr_gnt;
    logic [31:0]   s_rd_addr, s_wr_addr, s_wr_data, s_rd_data;
    logic [3:0]    s_wr_be;

    always #5 clk = ~clk;

    naive_bus_rr_arbiter #(
        .N_MASTER(N), .QUANTUM(Q), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr),
        .m_rd_gnt(m_rd_gnt), .m_rd_data(m_rd_data),
        .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr),
        .m_wr_be(m_wr_be), .m_wr_data(m_wr_data),
        .m_wr_gnt(m_wr_gnt),
        .s_rd_req(s_rd_req), .s_wr_req(s_wr_req),
        .s_rd_addr(s_rd_addr), .s_wr_addr(s_wr_addr),
        .s_wr_be(s_wr_be), .s_wr_data(s_wr_data),
        .s_rd_gnt(s_rd_gnt), .s_wr_gnt(s_wr_gnt),
        .s_rd_data(s_rd_data), .o_starve(o_starve)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        m_rd_req = '0; m_wr_req = '0;
        m_rd_addr = '0; m_wr_addr = '0;
        m_wr_data = '0; m_wr_be = '0;
        s_rd_gnt = 1'b0; s_wr_gnt = 1'b0;
        s_rd_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] rd, wr;
        logic         rg, wg;
        logic [N-1:0] erg, ewg;
        logic         esr, esw;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [N-1:0] rd, logic [N-1:0] wr,
                                logic rg, logic wg,
                                logic [N-1:0] erg, logic [N-1:0] ewg,
                                logic esr, logic esw);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rg = rg; v.wg = wg;
        v.erg = erg; v.ewg = ewg; v.esr = esr; v.esw = esw;
        return v;
    endfunction

    // Reference: rotate from owner+1 (index 0 when idle), owner checked last.
    function automatic int pick(logic [N-1:0] req, bit owned,
                                int own, int q);
        int st;
        if (req == '0) return -1;
        if (owned && req[own] && (q < Q || req == (3'b001 << own)))
            return own;
        st = owned ? (own + 1) % N : 0;
        for (int k = 0; k < N; k++)
            if (req[(st + k) % N]) return (st + k) % N;
        return -1;
    endfunction

    bit  mo_owned;
    int  mo_owner, mo_q, mo_rid;
    bit  mo_pend;

    initial begin
        clr_in();

        // Reset: outputs held at zero even with live requests.
        rst = 1'b1;
        m_rd_req = '1; m_wr_req = '1;
        m_rd_addr = {N*32{1'b1}};
        s_rd_gnt = 1'b1; s_wr_gnt = 1'b1;
        s_rd_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_rd_gnt", m_rd_gnt, 0);
        chk("rst_wr_gnt", m_wr_gnt, 0);
        chk("rst_s_req", {s_rd_req, s_wr_req}, 0);
        chk("rst_s_addr", s_rd_addr, 0);
        chk("rst_rd_data", m_rd_data, 0);
        chk("rst_starve", o_starve, 0);
        do_reset();

        // Vector table: quantum rotation, rd/wr collision, stall.
        for (int q = 0; q < 12; q++)
            vt.push_back(mk(0, 3'b111, 0, 1, 0,
                            3'b001 << (q / 4), 0, 1));
        vt.push_back(mk(0, 3'b111, 0, 1, 0, 3'b001, 0, 1));
        vt.push_back(mk(3'b001, 3'b001, 1, 1, 3'b001, 0, 1, 0));
        vt.push_back(mk(0, 3'b001, 1, 1, 0, 3'b001, 0, 1));
        vt.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(3'b100, 0, 1, 0, 3'b100, 0, 1, 0));
        for (int s = 0; s < 5; s++)
            vt.push_back(mk(3'b101, 0, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(3'b101, 0, 1, 0, 3'b100, 0, 1, 0));

        for (int i = 0; i < N; i++) begin
            m_wr_addr[i*32 +: 32] = 32'h1000_0000 + i;
            m_wr_data[i*32 +: 32] = 32'hA0A0_0000 + i;
            m_rd_addr[i*32 +: 32] = 32'h2000_0000 + i;
            m_wr_be[i*4 +: 4]     = 4'(i + 1);
        end
        for (int r = 0; r < vt.size(); r++) begin
            m_rd_req = vt[r].rd; m_wr_req = vt[r].wr;
            s_rd_gnt = vt[r].rg; s_wr_gnt = vt[r].wg;
            @(negedge clk);
            chk($sformatf("v%0d_rd_gnt", r), m_rd_gnt, vt[r].erg);
            chk($sformatf("v%0d_wr_gnt", r), m_wr_gnt, vt[r].ewg);
            chk($sformatf("v%0d_s_req", r), {s_rd_req, s_wr_req},
                {vt[r].esr, vt[r].esw});
            for (int i = 0; i < N; i++) begin
                if (vt[r].ewg[i]) begin
                    chk($sformatf("v%0d_s_wr_addr", r), s_wr_addr,
                        32'h1000_0000 + i);
                    chk($sformatf("v%0d_s_wr_data", r), s_wr_data,
                        32'hA0A0_0000 + i);
                    chk($sformatf("v%0d_s_wr_be", r), s_wr_be, i + 1);
                end
            end
            step();
        end

        // Single master 1: ten back-to-back reads with routed return.
        do_reset();
        s_rd_gnt = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            m_rd_req = (k < 10) ? 3'b010 : 3'b000;
            m_rd_addr[32 +: 32] = 32'h0002_0000 + 4 * k;
            s_rd_data = 32'hD000_0000 + k - 1;
            @(negedge clk);
            if (k < 10) begin
                chk("single_gnt", m_rd_gnt, 3'b010);
                chk("single_addr", s_rd_addr, 32'h0002_0000 + 4 * k);
            end
            if (k > 0)
                chk("single_data", m_rd_data,
                    {32'h0, 32'hD000_0000 + k - 1, 32'h0});
            step();
        end

        // Read to master 2, then reset drops the pending return.
        do_reset();
        m_rd_req = 3'b100; s_rd_gnt = 1'b1;
        @(negedge clk);
        chk("pend_gnt", m_rd_gnt, 3'b100);
        step();
        rst = 1'b1; m_rd_req = '0;
        s_rd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("pend_rst_data", m_rd_data, 0);
        chk("pend_rst_starve", o_starve, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("pend_after_data", m_rd_data, 0);
        m_rd_req = 3'b110;
        @(negedge clk);
        chk("pend_after_gnt", m_rd_gnt, 3'b010);
        step();

        // Starvation: master 1 requests while the slave withholds grant.
        do_reset();
        m_rd_req = 3'b010; s_rd_gnt = 1'b0;
        for (int c = 0; c < 6; c++) step();
        @(negedge clk);
        chk("starve_early", o_starve, 0);
        for (int c = 0; c < 4; c++) step();
        @(negedge clk);
`ifdef NB_ARB_STARVE_MON_EN
        chk("starve_set", o_starve, 3'b010);
`else
        chk("starve_set", o_starve, 0);
`endif
        s_rd_gnt = 1'b1;
        for (int c = 0; c < 3; c++) step();
        @(negedge clk);
`ifdef NB_ARB_STARVE_MON_EN
        chk("starve_sticky", o_starve, 3'b010);
`else
        chk("starve_sticky", o_starve, 0);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        mo_owned = 0; mo_owner = 0; mo_q = 0;
        mo_pend = 0; mo_rid = 0;
        for (int c = 0; c < 400; c++) begin
            int sel;
            bit esr, esw, rhs, whs;
            logic [N-1:0] erg, ewg;
            logic [N*32-1:0] edata;
            logic [31:0] era, ewa, ewd;
            logic [3:0] ebe;
            for (int i = 0; i < N; i++) begin
                m_rd_req[i] = ($urandom % 5) < 2;
                m_wr_req[i] = ($urandom % 5) < 2;
                m_rd_addr[i*32 +: 32] = $urandom;
                m_wr_addr[i*32 +: 32] = $urandom;
                m_wr_data[i*32 +: 32] = $urandom;
                m_wr_be[i*4 +: 4] = 4'($urandom);
            end
            s_rd_gnt = ($urandom % 4) != 0;
            s_wr_gnt = ($urandom % 4) != 0;
            s_rd_data = $urandom;
            sel = pick(m_rd_req | m_wr_req, mo_owned, mo_owner, mo_q);
            esr = 0; esw = 0; erg = '0; ewg = '0;
            era = '0; ewa = '0; ewd = '0; ebe = '0;
            if (sel >= 0) begin
                esr = m_rd_req[sel];
                esw = m_wr_req[sel] && !m_rd_req[sel];
                era = m_rd_addr[sel*32 +: 32];
                ewa = m_wr_addr[sel*32 +: 32];
                ewd = m_wr_data[sel*32 +: 32];
                ebe = m_wr_be[sel*4 +: 4];
            end
            rhs = esr && s_rd_gnt;
            whs = esw && s_wr_gnt;
            if (rhs) erg[sel] = 1'b1;
            if (whs) ewg[sel] = 1'b1;
            edata = '0;
            if (mo_pend) edata[mo_rid*32 +: 32] = s_rd_data;
            @(negedge clk);
            chk("rnd_rd_gnt", m_rd_gnt, erg);
            chk("rnd_wr_gnt", m_wr_gnt, ewg);
            chk("rnd_s_req", {s_rd_req, s_wr_req}, {esr, esw});
            chk("rnd_s_rd_addr", s_rd_addr, era);
            chk("rnd_s_wr", {s_wr_addr, s_wr_data, s_wr_be},
                {ewa, ewd, ebe});
            chk("rnd_rd_data", m_rd_data, edata);
            @(posedge clk);
            if (rhs || whs) begin
                if (sel == mo_owner) begin
                    mo_q = (mo_q + 1 > Q) ? Q : mo_q + 1;
                end else begin
                    mo_owner = sel;
                    mo_q = 1;
                end
                mo_owned = 1;
            end else if ((m_rd_req | m_wr_req) == '0 && mo_owned) begin
                mo_owned = 0;
                mo_q = 0;
            end
            mo_pend = rhs;
            mo_rid = (sel >= 0) ? sel : mo_rid;
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
